stream_input: RTL

STREAM_INPUT -- requirements
Module: stream_input

---
 rtl/matrix_stream_pkg.sv | 13 +
 rtl/matrix_index_counter.sv | 52 +++++
 rtl/stream_input.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/matrix_stream_pkg.sv
// Shared types and default widths for the matrix stream producer/consumer blocks.
package matrix_stream_pkg;

    localparam int unsigned MAX_WIDTH_LEN_DEF = 4;
    localparam int unsigned SIZE_VALUE_DEF    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        FLUSH = 2'd2
    } stream_state_e;

endpackage

// File: rtl/matrix_index_counter.sv
// Row-major (x fastest) index counter with wrap and last-element detection.
module matrix_index_counter
    import matrix_stream_pkg::*;
#(
    parameter int unsigned WIDTH = MAX_WIDTH_LEN_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             advance_i,
    input  logic [WIDTH-1:0] size_x_i,
    input  logic [WIDTH-1:0] size_y_i,
    output logic [WIDTH-1:0] x_o,
    output logic [WIDTH-1:0] y_o,
    output logic             last_c_o
);

    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;

    assign last_c_o = (x_q == size_x_i) && (y_q == size_y_i);
    assign x_o      = x_q;
    assign y_o      = y_q;

    // y returns to 0 after the last element so the counter idles cleanly.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear_i) begin
            x_d = '0;
            y_d = '0;
        end else if (advance_i) begin
            if (x_q == size_x_i) begin
                x_d = '0;
                y_d = last_c_o ? '0 : y_q + WIDTH'(1);
            end else begin
                x_d = x_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/stream_input.sv
// Receives a row-major element stream and writes it into matrix memory.
// Optional running checksum output enabled by STREAM_INPUT_CHECKSUM_EN.
module stream_input
    import matrix_stream_pkg::*;
#(
    parameter int unsigned maxWidthLen = MAX_WIDTH_LEN_DEF,
    parameter int unsigned sizeValue   = SIZE_VALUE_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [maxWidthLen-1:0]      sizeX,
    input  logic [maxWidthLen-1:0]      sizeY,
    input  logic                        in_valid,
    input  logic signed [sizeValue-1:0] in_data,
    output logic                        in_ready,
    output logic                        wr_en,
    output logic [maxWidthLen-1:0]      wr_x,
    output logic [maxWidthLen-1:0]      wr_y,
    output logic signed [sizeValue-1:0] wr_data,
    output logic                        busy,
    output logic                        done
`ifdef STREAM_INPUT_CHECKSUM_EN
    ,
    output logic signed [sizeValue-1:0] checksum
`endif
);

    stream_state_e state_q, state_d;

    logic                        load_c;
    logic                        accept_c;
    logic                        last_c;
    logic [maxWidthLen-1:0]      cnt_x, cnt_y;
    logic [maxWidthLen-1:0]      size_x_q, size_x_d;
    logic [maxWidthLen-1:0]      size_y_q, size_y_d;
    logic                        in_ready_q, busy_q, done_q, wr_en_q;
    logic [maxWidthLen-1:0]      wr_x_q, wr_x_d;
    logic [maxWidthLen-1:0]      wr_y_q, wr_y_d;
    logic signed [sizeValue-1:0] wr_data_q, wr_data_d;

    // Next state, size latch and write-port staging.
    always_comb begin
        state_d   = state_q;
        load_c    = 1'b0;
        accept_c  = 1'b0;
        size_x_d  = size_x_q;
        size_y_d  = size_y_q;
        wr_x_d    = wr_x_q;
        wr_y_d    = wr_y_q;
        wr_data_d = wr_data_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RECV;
                    load_c  = 1'b1;
                end
            end
            RECV: begin
                // A start here abandons the matrix and drops any coincident beat.
                if (start) begin
                    load_c = 1'b1;
                end else if (in_valid) begin
                    accept_c = 1'b1;
                    if (last_c) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (start) begin
                    state_d = RECV;
                    load_c  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load_c) begin
            size_x_d = sizeX;
            size_y_d = sizeY;
        end
        if (accept_c) begin
            wr_x_d    = cnt_x;
            wr_y_d    = cnt_y;
            wr_data_d = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            size_x_q   <= '0;
            size_y_q   <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_x_q     <= '0;
            wr_y_q     <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            size_x_q   <= size_x_d;
            size_y_q   <= size_y_d;
            in_ready_q <= (state_d == RECV);
            busy_q     <= (state_d != IDLE);
            done_q     <= (state_d == FLUSH);
            wr_en_q    <= accept_c;
            wr_x_q     <= wr_x_d;
            wr_y_q     <= wr_y_d;
            wr_data_q  <= wr_data_d;
        end
    end

    matrix_index_counter #(
        .WIDTH (maxWidthLen)
    ) u_idx (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (load_c),
        .advance_i (accept_c),
        .size_x_i  (size_x_q),
        .size_y_i  (size_y_q),
        .x_o       (cnt_x),
        .y_o       (cnt_y),
        .last_c_o  (last_c)
    );

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign wr_en    = wr_en_q;
    assign wr_x     = wr_x_q;
    assign wr_y     = wr_y_q;
    assign wr_data  = wr_data_q;

`ifdef STREAM_INPUT_CHECKSUM_EN
    logic signed [sizeValue-1:0] checksum_q, checksum_d;

    // Wrapping sum of accepted beats; complete in the done cycle.
    always_comb begin
        checksum_d = checksum_q;
        if (load_c) begin
            checksum_d = '0;
        end else if (accept_c) begin
            checksum_d = checksum_q + in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule
